ring_buffer_ctrl: RTL and testbench

Sequencer that owns one `ring_buffer` instance in the convolution accelerator and moves a programmed burst of data sets from a producer stream (input-feature loader) through the buffer to a consumer stream (PE array feed). It generates the buffer's `wen`/`ren` from valid/ready handshakes, tracks occupancy, and absorbs the buffer's one-cycle read latency with a 2-entry output skid. A `start`/`done` pair exposes it to the layer-level scheduler.

---
 rtl/ring_buffer_pkg.sv | 20 ++
 rtl/ring_buffer_ctrl_skid.sv | 69 ++++++
 rtl/ring_buffer_ctrl.sv | 137 +++++++++++++
 tb/tb_ring_buffer_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_buffer_pkg.sv
// Shared state encoding, data-set type and default sizing for the ring buffer controller.
// Latency: none, declarations only.
// Backpressure: not applicable.
package ring_buffer_pkg;

  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_DATA_OF_SET = 4;
  localparam int DEF_BUFFER_SIZE = 4;
  localparam int DEF_MAX_BURST   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } ctrl_state_t;

  typedef logic [DEF_DATA_OF_SET*DEF_DATA_WIDTH-1:0] data_set_t;

endpackage

// File: rtl/ring_buffer_ctrl_skid.sv
// Two-entry output FIFO that catches ring buffer read data one cycle after each read issue.
// Latency: read issued at t is loaded at the end of t+1 and presented from t+2.
// Backpressure: credit only while held entries (net of this cycle's pop) plus the in-flight read stay below two.
module ring_buffer_ctrl_skid
  import ring_buffer_pkg::*;
#(
  parameter int W = DEF_DATA_OF_SET * DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_issue,
  input  logic [W-1:0] rd_data,
  input  logic         pop,
  output logic         vld,
  output logic [W-1:0] head,
  output logic         credit
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         inflight;
  logic         pop_ok;
  logic [2:0]   used;

  assign vld    = (cnt != 2'd0);
  assign head   = ent0;
  assign pop_ok = pop && vld;

  // Counting the current pop as already freed keeps one set per cycle flowing with the consumer ready.
  always_comb begin
    used   = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop_ok};
    credit = (used < 3'd2);
  end

  // Load returning read data at the tail and shift on pop, preserving FIFO order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0     <= '0;
      ent1     <= '0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case ({inflight, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= rd_data;
          else             ent1 <= rd_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= rd_data;
          end else begin
            ent0 <= ent1;
            ent1 <= rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ring_buffer_ctrl.sv
// Burst sequencer moving producer data sets through one ring buffer to the consumer; optional RING_BUFFER_CTRL_CHECK_EN adds a sticky err.
// Latency: write at t -> buf_ren at t+1 earliest -> m_valid at t+3; last consumer handshake at t -> done at t+1.
// Backpressure: s_ready drops on buf_full or once the burst is written; reads stall on empty buffer or a full skid.
module ring_buffer_ctrl
  import ring_buffer_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  DATA_OF_SET = DEF_DATA_OF_SET,
  parameter int  BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int  MAX_BURST   = DEF_MAX_BURST,
  localparam int SW = DATA_OF_SET * DATA_WIDTH,
  localparam int CW = $clog2(MAX_BURST + 1),
  localparam int OW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] burst_len,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [SW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [SW-1:0] m_data,
  output logic          buf_wen,
  output logic          buf_ren,
  output logic [SW-1:0] buf_din,
  input  logic [SW-1:0] buf_dout,
  input  logic          buf_full,
  input  logic          buf_empty,
  output logic [OW-1:0] occupancy,
  output logic          err
);

  ctrl_state_t   state;
  ctrl_state_t   state_nxt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] iss_cnt;
  logic          skid_credit;
  logic          rd_hs;
  logic          in_xfer;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign in_xfer = (state == ST_STREAM) || (state == ST_DRAIN);
  assign s_ready = (state == ST_STREAM) && !buf_full && (wr_cnt < len_q);
  assign buf_wen = s_valid && s_ready;
  assign buf_din = (state == ST_STREAM) ? s_data : '0;
  assign buf_ren = in_xfer && !buf_empty && skid_credit && (iss_cnt < len_q);
  assign rd_hs   = m_valid && m_ready;

  ring_buffer_ctrl_skid #(.W(SW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .rd_issue (buf_ren),
    .rd_data  (buf_dout),
    .pop      (rd_hs),
    .vld      (m_valid),
    .head     (m_data),
    .credit   (skid_credit)
  );

  // Burst phase: stream until the last write, drain until the last consumer handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (burst_len == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (buf_wen && (wr_cnt + CW'(1) == len_q)) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (rd_hs && (rd_cnt + CW'(1) == len_q)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Burst length and progress counters; reset by start so a new burst begins from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      iss_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        len_q   <= burst_len;
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        iss_cnt <= '0;
      end
    end else begin
      if (buf_wen) wr_cnt  <= wr_cnt + CW'(1);
      if (rd_hs)   rd_cnt  <= rd_cnt + CW'(1);
      if (buf_ren) iss_cnt <= iss_cnt + CW'(1);
    end
  end

  // Buffer occupancy mirror: up on write, down on read, flat on both or neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else begin
      case ({buf_wen, buf_ren})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef RING_BUFFER_CTRL_CHECK_EN
  logic err_q;
  assign err = err_q;

  // Sticky flag for buffer flags disagreeing with the local count, or a start while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((buf_full != (occupancy == OW'(BUFFER_SIZE))) ||
                 (buf_empty != (occupancy == '0)) ||
                 (start && busy)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
module tb_ring_buffer_ctrl;

  localparam int DW = 4;
  localparam int DS = 4;
  localparam int BS = 4;
  localparam int MB = 16;
  localparam int SW = DW * DS;
  localparam int CW = $clog2(MB + 1);
  localparam int OW = $clog2(BS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          busy, done;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [SW-1:0] m_data;
  logic          buf_wen, buf_ren;
  logic [SW-1:0] buf_din;
  logic [SW-1:0] buf_dout;
  logic          buf_full, buf_empty;
  logic [OW-1:0] occupancy;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_buffer_ctrl #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .BUFFER_SIZE(BS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .buf_wen(buf_wen), .buf_ren(buf_ren), .buf_din(buf_din), .buf_dout(buf_dout),
    .buf_full(buf_full), .buf_empty(buf_empty), .occupancy(occupancy), .err(err)
  );

  // Behavioural ring buffer: registered read data, flags from an entry count.
  logic [SW-1:0] bm_mem [BS];
  int            bm_cnt, bm_wp, bm_rp;
  logic          force_empty = 1'b0;
  assign buf_full  = (bm_cnt == BS);
  assign buf_empty = (bm_cnt == 0) || force_empty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bm_cnt <= 0; bm_wp <= 0; bm_rp <= 0; buf_dout <= '0;
    end else begin
      if (buf_wen && bm_cnt < BS) begin
        bm_mem[bm_wp] <= buf_din;
        bm_wp <= (bm_wp + 1) % BS;
      end
      if (buf_ren && bm_cnt > 0) begin
        buf_dout <= bm_mem[bm_rp];
        bm_rp <= (bm_rp + 1) % BS;
      end
      bm_cnt <= bm_cnt + ((buf_wen && bm_cnt < BS) ? 1 : 0) - ((buf_ren && bm_cnt > 0) ? 1 : 0);
    end
  end

  // Observations from one burst, judged by the scenario tasks.
  logic [SW-1:0] src [16];
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] got_q [$];
  int   r_first_wr, r_first_mv, r_last_hs, r_done_cyc, r_done_pulses, r_wen, r_ren;
  int   r_occ_bad, r_wen_bad, r_srdy_bad, r_skid_max, r_occ_at_full;
  bit   r_full_seen, r_timeout, r_err_seen;
  logic r_busy_first, r_srdy_first, r_busy_after;

  // m_mode: 0 random m_ready, 1 hold m_ready low until the producer stalls on full, 2 toggle 1,0,1,0.
  task automatic run_burst(input int len, input int s_pct, input int m_pct, input int m_mode,
                           input bit use_src, input int abort_at);
    int acc, rd, iss, pidx, cyc, outstanding;
    bit released, fin;
    acc = 0; rd = 0; iss = 0; pidx = 0; released = 0; fin = 0;
    r_first_wr = -1; r_first_mv = -1; r_last_hs = -1; r_done_cyc = -1; r_done_pulses = 0;
    r_wen = 0; r_ren = 0; r_occ_bad = 0; r_wen_bad = 0; r_srdy_bad = 0; r_skid_max = 0;
    r_occ_at_full = -1; r_full_seen = 0; r_err_seen = 0; r_busy_after = 1'b1;
    r_busy_first = 1'b0; r_srdy_first = 1'b0;
    exp_q.delete(); got_q.delete();
    if (!use_src) for (int i = 0; i < 16; i++) src[i] = SW'($urandom);
    @(negedge clk); start = 1'b1; burst_len = CW'(len);
    @(negedge clk); start = 1'b0; burst_len = '0;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      s_valid = (pidx < len) && ($urandom_range(99) < s_pct);
      s_data  = s_valid ? src[pidx % 16] : '0;
      case (m_mode)
        1:       m_ready = released && ($urandom_range(99) < m_pct);
        2:       m_ready = (cyc % 2 == 0);
        default: m_ready = ($urandom_range(99) < m_pct);
      endcase
      #1;
      outstanding = iss - rd;
      if (outstanding > r_skid_max) r_skid_max = outstanding;
      if (cyc == 0) begin r_busy_first = busy; r_srdy_first = s_ready; end
      if (buf_wen !== (s_valid && s_ready)) r_wen_bad++;
      if (s_ready !== ((acc < len) && (bm_cnt < BS))) r_srdy_bad++;
      if (occupancy !== OW'(bm_cnt)) r_occ_bad++;
      if (err !== 1'b0) r_err_seen = 1;
      if (m_mode == 1 && !released && !s_ready && buf_full) begin
        r_full_seen = 1; r_occ_at_full = int'(occupancy); released = 1;
      end
      if (buf_wen) r_wen++;
      if (buf_ren) begin r_ren++; iss++; end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        if (acc == 0) r_first_wr = cyc;
        acc++; pidx++;
      end
      if (m_valid && r_first_mv < 0) r_first_mv = cyc;
      if (m_valid && m_ready) begin got_q.push_back(m_data); rd++; r_last_hs = cyc; end
      if (done) begin r_done_pulses++; r_done_cyc = cyc; end
      if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) r_busy_after = busy;
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 2) fin = 1;
      if (abort_at > 0 && acc == abort_at) fin = 1;
      @(negedge clk);
    end
    r_timeout = !fin;
    s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
  endtask

  task automatic test_reset;
    s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b1;
    rst = 1'b0; #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if ({buf_wen, buf_ren} !== 2'b00) begin errors++; $display("FAIL reset_wen_ren got %b want 00", {buf_wen, buf_ren}); end
    checks++; if (occupancy !== '0)   begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (m_data !== '0 || buf_din !== '0) begin errors++; $display("FAIL reset_data got m=%h din=%h want 0", m_data, buf_din); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    src[0] = 16'h1234; src[1] = 16'h1111; src[2] = 16'h2222;
    run_burst(3, 100, 100, 0, 1, 0);
    checks++; if (r_timeout)           begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    checks++; if (r_busy_first !== 1'b1 || r_srdy_first !== 1'b1) begin errors++; $display("FAIL basic_start_resp got busy=%0b rdy=%0b want 1 1", r_busy_first, r_srdy_first); end
    checks++; if (got_q.size() != 3)   begin errors++; $display("FAIL basic_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== src[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got_q[i], src[i]); end
    end
    checks++; if (r_first_mv - r_first_wr != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", r_first_mv - r_first_wr); end
    checks++; if (r_last_hs - r_first_mv != 2)  begin errors++; $display("FAIL basic_throughput got %0d want 2", r_last_hs - r_first_mv); end
    checks++; if (r_done_pulses != 1)  begin errors++; $display("FAIL basic_done_pulses got %0d want 1", r_done_pulses); end
    checks++; if (r_done_cyc - r_last_hs != 1)  begin errors++; $display("FAIL basic_done_lat got %0d want 1", r_done_cyc - r_last_hs); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b want 0", r_busy_after); end
    checks++; if (r_wen != 3 || r_ren != 3) begin errors++; $display("FAIL basic_enables got wen=%0d ren=%0d want 3 3", r_wen, r_ren); end
    checks++; if (r_occ_bad + r_wen_bad + r_srdy_bad != 0) begin errors++; $display("FAIL basic_protocol got occ=%0d wen=%0d rdy=%0d want 0", r_occ_bad, r_wen_bad, r_srdy_bad); end
  endtask

  task automatic test_full_stall;
    run_burst(6, 100, 100, 1, 0, 0);
    checks++; if (!r_full_seen || r_occ_at_full != BS) begin errors++; $display("FAIL full_stall got seen=%0b occ=%0d want 1 %0d", r_full_seen, r_occ_at_full, BS); end
    checks++; if (got_q.size() != 6 || exp_q.size() != 6) begin errors++; $display("FAIL full_count got %0d/%0d want 6", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== src[i]) begin errors++; $display("FAIL full_data[%0d] got %h want %h", i, got_q[i], src[i]); end
    end
    checks++; if (r_done_pulses != 1 || r_timeout) begin errors++; $display("FAIL full_done got %0d timeout=%0b want 1 0", r_done_pulses, r_timeout); end
    checks++; if (r_occ_bad + r_srdy_bad != 0) begin errors++; $display("FAIL full_protocol got occ=%0d rdy=%0d want 0", r_occ_bad, r_srdy_bad); end
  endtask

  task automatic test_zero_len;
    run_burst(0, 100, 100, 0, 0, 0);
    checks++; if (r_done_cyc != 0)     begin errors++; $display("FAIL zero_done_cycle got %0d want 0", r_done_cyc); end
    checks++; if (r_done_pulses != 1)  begin errors++; $display("FAIL zero_done_pulses got %0d want 1", r_done_pulses); end
    checks++; if (r_wen != 0 || r_ren != 0) begin errors++; $display("FAIL zero_enables got wen=%0d ren=%0d want 0 0", r_wen, r_ren); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %0b want 0", r_busy_after); end
  endtask

  task automatic test_toggle;
    run_burst(8, 70, 0, 2, 0, 0);
    checks++; if (got_q.size() != 8)   begin errors++; $display("FAIL toggle_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== src[i]) begin errors++; $display("FAIL toggle_data[%0d] got %h want %h", i, got_q[i], src[i]); end
    end
    checks++; if (r_skid_max > 2)      begin errors++; $display("FAIL toggle_skid got %0d want <=2", r_skid_max); end
    checks++; if (r_done_pulses != 1 || r_timeout) begin errors++; $display("FAIL toggle_done got %0d timeout=%0b want 1 0", r_done_pulses, r_timeout); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(MB, 1);
      run_burst(len, $urandom_range(100, 30), $urandom_range(100, 30), 0, 0, 0);
      checks++; if (got_q.size() != len || exp_q.size() != len) begin errors++; $display("FAIL rand%0d_count got %0d/%0d want %0d", n, got_q.size(), exp_q.size(), len); end
      for (int i = 0; i < len && i < got_q.size() && i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got %h want %h", n, i, got_q[i], exp_q[i]); end
      end
      checks++; if (r_done_pulses != 1 || r_timeout || r_done_cyc - r_last_hs != 1) begin errors++; $display("FAIL rand%0d_done got pulses=%0d timeout=%0b lat=%0d want 1 0 1", n, r_done_pulses, r_timeout, r_done_cyc - r_last_hs); end
      checks++; if (r_occ_bad + r_wen_bad + r_srdy_bad != 0 || r_skid_max > 2 || r_err_seen) begin errors++; $display("FAIL rand%0d_protocol got occ=%0d wen=%0d rdy=%0d skid=%0d err=%0b want 0 0 0 <=2 0", n, r_occ_bad, r_wen_bad, r_srdy_bad, r_skid_max, r_err_seen); end
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    run_burst(8, 100, 0, 0, 0, 2);
    s_valid = 1'b1; s_data = src[2];
    rst = 1'b0; #1;
    checks++; if ({busy, done, s_ready, m_valid, buf_wen, buf_ren, err} !== 7'b0) begin errors++; $display("FAIL midrst_ctrl got %b want 0000000", {busy, done, s_ready, m_valid, buf_wen, buf_ren, err}); end
    checks++; if (occupancy !== '0 || m_data !== '0 || buf_din !== '0) begin errors++; $display("FAIL midrst_data got occ=%0d m=%h din=%h want 0", occupancy, m_data, buf_din); end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (done) pulses++; end
    s_valid = 1'b0; s_data = '0;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; if (done) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
    run_burst(5, 80, 80, 0, 0, 0);
    checks++; if (got_q.size() != 5 || r_done_pulses != 1 || r_timeout) begin errors++; $display("FAIL midrst_rerun got n=%0d done=%0d timeout=%0b want 5 1 0", got_q.size(), r_done_pulses, r_timeout); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== src[i]) begin errors++; $display("FAIL midrst_data[%0d] got %h want %h", i, got_q[i], src[i]); end
    end
  endtask

`ifdef RING_BUFFER_CTRL_CHECK_EN
  task automatic test_err;
    int guard;
    @(negedge clk); start = 1'b1; burst_len = CW'(4);
    @(negedge clk); start = 1'b0; burst_len = '0;
    s_valid = 1'b1; s_data = 16'h5A5A; m_ready = 1'b0;
    guard = 0;
    while (!(occupancy == OW'(2) && !s_ready && !buf_ren) && guard < 40) begin @(negedge clk); guard++; end
    checks++; if (guard >= 40) begin errors++; $display("FAIL err_setup got timeout want occupancy 2"); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pre got %0b want 0", err); end
    force_empty = 1'b1;
    @(negedge clk); force_empty = 1'b0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
    s_valid = 1'b0;
    rst = 1'b0; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", err); end
    @(negedge clk); rst = 1'b1;
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset;
    test_basic;
    test_full_stall;
    test_zero_len;
    test_toggle;
    test_random;
    test_reset_mid;
`ifdef RING_BUFFER_CTRL_CHECK_EN
    test_err;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
